// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Brief    : Fetch stage. Holds the PC, runs the imem req/ack handshake, loads
//            IF/ID, and squashes fetches on redirect/flush.
//            Optional: FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit #(
  parameter int                   PC_WIDTH  = 32,
  parameter int                   IWIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [IWIDTH-1:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic                fr_clk,
  input  logic                fr_rst,
  input  logic                fr_i_ce,
  input  logic                fr_i_stall,
  input  logic                fr_i_flush,
  input  logic                fr_i_change_pc,
  input  logic [PC_WIDTH-1:0] fr_i_next_pc,
  output logic                fr_o_imem_req,
  output logic [PC_WIDTH-1:0] fr_o_imem_addr,
  input  logic                fr_i_imem_ack,
  input  logic [IWIDTH-1:0]   fr_i_imem_data,
  output logic [IWIDTH-1:0]   fr_o_instr,
  output logic [PC_WIDTH-1:0] fr_o_pc,
  output logic                fr_o_ce
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                fr_o_misaligned
`endif
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                squash_q, squash_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] opc_q, opc_d;
  logic                ce_q, ce_d;
  logic [IWIDTH-1:0]   buf_instr_q, buf_instr_d;
  logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic                mis_q;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_d;
  assign w_target        = fr_i_next_pc;
  assign fr_o_misaligned = mis_q;
`else
  assign mis_q    = 1'b0;
  assign w_target = fr_i_next_pc & ~PC_WIDTH'(3);
`endif

  assign w_ack = (state_q == c_wait) && fr_i_imem_ack;

  // State register and all registered outputs
  always_ff @(posedge fr_clk) begin
    if (fr_rst) begin
      state_q     <= c_idle;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      instr_q     <= NOP_INSTR;
      opc_q       <= '0;
      ce_q        <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      opc_q       <= opc_d;
      ce_q        <= ce_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (fr_i_change_pc || fr_i_flush) begin
      if ((state_q == c_hold) || w_ack) state_d = c_idle;
    end else begin
      case (state_q)
        c_idle:  if (fr_i_ce && !fr_i_stall && !mis_q) state_d = c_wait;
        c_wait: begin
          if (fr_i_imem_ack) begin
            if (squash_q)         state_d = c_idle;
            else if (!fr_i_stall) state_d = fr_i_ce ? c_wait : c_idle;
            else                  state_d = c_hold;
          end
        end
        c_hold:  if (!fr_i_stall) state_d = c_idle;
        default: state_d = c_idle;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    pc_d        = pc_q;
    squash_d    = squash_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    opc_d       = opc_q;
    ce_d        = fr_i_stall ? ce_q : 1'b0;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    if (fr_i_change_pc || fr_i_flush) begin
      ce_d    = 1'b0;
      instr_d = NOP_INSTR;
      if (fr_i_change_pc) begin
        pc_d = w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d = |fr_i_next_pc[1:0];
`endif
      end
      // An outstanding request must still see its ack; mark it for dropping.
      if (state_q == c_wait) begin
        if (fr_i_imem_ack) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
        end else begin
          squash_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        c_idle: begin
          if (fr_i_ce && !fr_i_stall && !mis_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
        c_wait: begin
          if (fr_i_imem_ack) begin
            if (squash_q) begin
              squash_d = 1'b0;
              req_d    = 1'b0;
            end else if (!fr_i_stall) begin
              instr_d = fr_i_imem_data;
              opc_d   = addr_q;
              ce_d    = 1'b1;
              pc_d    = pc_q + c_pc_step;
              if (fr_i_ce) addr_d = pc_q + c_pc_step;
              else         req_d  = 1'b0;
            end else begin
              buf_instr_d = fr_i_imem_data;
              buf_pc_d    = addr_q;
              req_d       = 1'b0;
            end
          end
        end
        c_hold: begin
          if (!fr_i_stall) begin
            instr_d = buf_instr_q;
            opc_d   = buf_pc_q;
            ce_d    = 1'b1;
            pc_d    = pc_q + c_pc_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign fr_o_imem_req  = req_q;
  assign fr_o_imem_addr = addr_q;
  assign fr_o_instr     = instr_q;
  assign fr_o_pc        = opc_q;
  assign fr_o_ce        = ce_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_unit
// Brief    : Directed self-checking bench for fetch_redirect_unit with a
//            programmable-latency instruction memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_unit;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, ce, stall, flush, change_pc;
  logic [31:0] next_pc;
  logic        req, ack;
  logic [31:0] addr, data;
  logic [31:0] instr, opc;
  logic        oce;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis;
`endif

  int lat;
  int cnt;
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .fr_clk         (clk),
    .fr_rst         (rst),
    .fr_i_ce        (ce),
    .fr_i_stall     (stall),
    .fr_i_flush     (flush),
    .fr_i_change_pc (change_pc),
    .fr_i_next_pc   (next_pc),
    .fr_o_imem_req  (req),
    .fr_o_imem_addr (addr),
    .fr_i_imem_ack  (ack),
    .fr_i_imem_data (data),
    .fr_o_instr     (instr),
    .fr_o_pc        (opc),
    .fr_o_ce        (oce)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fr_o_misaligned(mis)
`endif
  );

  // Memory: ack after 'lat' cycles of req, data is a tag of the address
  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign ack  = req && (cnt == lat);
  assign data = dat(addr);

  always @(posedge clk) begin
    if (req && !ack) cnt <= cnt + 1;
    else             cnt <= 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cnt = 0; lat = 0;
    rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0;
    change_pc = 1'b0; next_pc = '0;
    step(); step();
    chk("rst_req",   32'(req),  32'd0);
    chk("rst_addr",  addr,      32'h0);
    chk("rst_instr", instr,     c_nop);
    chk("rst_pc",    opc,       32'h0);
    chk("rst_ce",    32'(oce),  32'd0);
    rst = 1'b0;

    // Zero-wait back-to-back fetch
    ce = 1'b1; step();
    chk("a_req",   32'(req), 32'd1);
    chk("a_addr0", addr,     32'h0);
    chk("a_ce0",   32'(oce), 32'd0);
    step();
    chk("a_ce1",   32'(oce), 32'd1);
    chk("a_pc0",   opc,      32'h0);
    chk("a_ins0",  instr,    dat(32'h0));
    chk("a_addr4", addr,     32'h4);
    step();
    chk("a_pc4",   opc,      32'h4);
    chk("a_addr8", addr,     32'h8);
    chk("a_ce2",   32'(oce), 32'd1);
    step();
    chk("a_pc8",   opc,      32'h8);
    chk("a_addrc", addr,     32'hC);
    ce = 1'b0; step();
    chk("a_pcc",   opc,      32'hC);
    chk("a_cec",   32'(oce), 32'd1);
    chk("a_reqlo", 32'(req), 32'd0);
    step();
    chk("a_idle_ce",  32'(oce), 32'd0);
    chk("a_idle_req", 32'(req), 32'd0);

    // Three wait cycles: req held four cycles, one ce pulse
    lat = 3; ce = 1'b1; step();
    chk("b_req0",  32'(req), 32'd1);
    chk("b_addr0", addr,     32'h10);
    ce = 1'b0; step();
    chk("b_req1",  32'(req), 32'd1);
    chk("b_ce1",   32'(oce), 32'd0);
    step();
    chk("b_req2",  32'(req), 32'd1);
    step();
    chk("b_req3",  32'(req), 32'd1);
    chk("b_addr3", addr,     32'h10);
    step();
    chk("b_ce",    32'(oce), 32'd1);
    chk("b_pc",    opc,      32'h10);
    chk("b_ins",   instr,    dat(32'h10));
    chk("b_reqlo", 32'(req), 32'd0);
    step();
    chk("b_cepulse", 32'(oce), 32'd0);

    // Stall on ack: HOLD keeps IF/ID, release loads the buffered word
    lat = 1; ce = 1'b1; step();
    chk("c_addr",  addr,     32'h14);
    ce = 1'b0; step();
    stall = 1'b1; step();
    chk("c_reqlo", 32'(req), 32'd0);
    chk("c_hold_pc", opc,    32'h10);
    step();
    chk("c_hold_ins", instr, dat(32'h10));
    chk("c_hold_ce", 32'(oce), 32'd0);
    stall = 1'b0; step();
    chk("c_pc",    opc,      32'h14);
    chk("c_ins",   instr,    dat(32'h14));
    chk("c_ce",    32'(oce), 32'd1);
    step();
    chk("c_ce_lo", 32'(oce), 32'd0);

    // Redirect while waiting: in-flight word dropped, refetch from target
    lat = 2; ce = 1'b1; step();
    chk("d_addr",  addr,     32'h18);
    step();
    change_pc = 1'b1; next_pc = 32'h100; step();
    chk("d_req_held", 32'(req), 32'd1);
    chk("d_addr_held", addr,    32'h18);
    chk("d_ins_nop", instr,     c_nop);
    chk("d_ce0",  32'(oce),     32'd0);
    change_pc = 1'b0; step();
    chk("d_drop_req", 32'(req), 32'd0);
    chk("d_drop_ce",  32'(oce), 32'd0);
    lat = 0; step();
    chk("d_newaddr", addr,      32'h100);
    chk("d_newreq",  32'(req),  32'd1);
    step();
    chk("d_pc100", opc,      32'h100);
    chk("d_ce100", 32'(oce), 32'd1);
    chk("d_ins100", instr,   dat(32'h100));
    chk("d_addr104", addr,   32'h104);
    ce = 1'b0; step();
    chk("d_pc104", opc,      32'h104);

    // Flush wins over stall
    flush = 1'b1; stall = 1'b1; step();
    chk("e_ce",    32'(oce), 32'd0);
    chk("e_ins",   instr,    c_nop);
    flush = 1'b0; stall = 1'b0;

    // Flush with request in flight: dropped, pc unchanged so same address refetched
    lat = 1; ce = 1'b1; step();
    chk("f_addr",  addr,     32'h108);
    flush = 1'b1; step();
    chk("f_req",   32'(req), 32'd1);
    flush = 1'b0; step();
    chk("f_drop",  32'(req), 32'd0);
    step();
    chk("f_readdr", addr,    32'h108);
    ce = 1'b0; step();
    step();
    chk("f_pc",    opc,      32'h108);
    chk("f_ce",    32'(oce), 32'd1);

    // PC wrap at top of address space
    change_pc = 1'b1; next_pc = 32'hFFFF_FFFC; step();
    change_pc = 1'b0; lat = 0; ce = 1'b1; step();
    chk("g_addr",  addr,     32'hFFFF_FFFC);
    step();
    chk("g_pc",    opc,      32'hFFFF_FFFC);
    chk("g_wrap",  addr,     32'h0);
    ce = 1'b0; step();
    chk("g_pc0",   opc,      32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    change_pc = 1'b1; next_pc = 32'h102; step();
    chk("h_mis",   32'(mis), 32'd1);
    change_pc = 1'b0; ce = 1'b1; step();
    chk("h_noreq", 32'(req), 32'd0);
    chk("h_ce0",   32'(oce), 32'd0);
    change_pc = 1'b1; next_pc = 32'h200; step();
    chk("h_clr",   32'(mis), 32'd0);
    change_pc = 1'b0; step();
    chk("h_addr",  addr,     32'h200);
`else
    change_pc = 1'b1; next_pc = 32'h202; step();
    change_pc = 1'b0; ce = 1'b1; step();
    chk("h_align", addr,     32'h200);
`endif
    ce = 1'b0; step();
    chk("h_pc",    opc,      32'h200);

    // Redirect out of HOLD under stall: buffer discarded
    lat = 1; ce = 1'b1; step();
    chk("j_addr",  addr,     32'h204);
    ce = 1'b0; stall = 1'b1; step();
    step();
    chk("j_hold",  32'(req), 32'd0);
    change_pc = 1'b1; next_pc = 32'h300; step();
    chk("j_ce",    32'(oce), 32'd0);
    chk("j_ins",   instr,    c_nop);
    change_pc = 1'b0; stall = 1'b0; ce = 1'b1; step();
    chk("j_addr300", addr,   32'h300);
    chk("j_req",   32'(req), 32'd1);

    // Reset mid-WAIT
    rst = 1'b1; step();
    chk("k_req",   32'(req), 32'd0);
    chk("k_addr",  addr,     32'h0);
    chk("k_ce",    32'(oce), 32'd0);
    rst = 1'b0; ce = 1'b0; step();
    chk("k_idle",  32'(req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
